// File: rtl/txt_pkg.sv
// Shared constants for the pipelined text-mode renderer.
// Holds the attribute byte layout, the pipeline latency and the cursor height.
package txt_pkg;

  localparam int ATTR_FG_LSB   = 0;
  localparam int ATTR_FG_MSB   = 3;
  localparam int ATTR_BG_LSB   = 4;
  localparam int ATTR_BG_MSB   = 6;
  localparam int ATTR_BLINK    = 7;

  localparam int TXT_LAT       = 5;
  localparam int TXT_CUR_LINES = 2;

endpackage

// File: rtl/txt_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset.
// Carries sync signals and per-pixel side-band data alongside the render pipeline.
module txt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; reset clears every stage so in-flight data is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/txt_render_pipe.sv
// Pipelined text-mode renderer: raster position -> text RAM -> glyph ROM -> colour index.
// Five-edge latency from posx/posy/de/hs/vs to pix/de_out/hs_out/vs_out.
//   E1 txt_addr + side-band, E2 RAM read, E3 gly_addr + attribute, E4 ROM read, E5 pix.
// Optional block cursor enabled with macro TXT_CURSOR_EN (adds cur_en/cur_col/cur_row).
module txt_render_pipe
  import txt_pkg::*;
#(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int TXT_AW       = 12,
  parameter int GLY_AW       = 12,
  parameter int CHR_BASE     = 32,
  parameter int PIX_W        = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_W-1:0]    posx,
  input  logic [Y_W-1:0]    posy,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [7:0]        txt_chr,
  input  logic [7:0]        txt_attr,
  output logic [GLY_AW-1:0] gly_addr,
  input  logic [7:0]        gly_row,
  output logic [PIX_W-1:0]  pix,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out
`ifdef TXT_CURSOR_EN
  ,
  input  logic              cur_en,
  input  logic [6:0]        cur_col,
  input  logic [4:0]        cur_row
`endif
);

  localparam int BIT_W   = 3;
  localparam int SUB_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SBA_W   = 1 + BIT_W + 1 + SUB_W;
  localparam int SBB_W   = 1 + BIT_W + 1;
  localparam logic [7:0] CHR_CODE = 8'(CHR_BASE);

  // Stage 0 (combinational from the raster inputs)
  logic [X_W-1:0]    col_s0;
  logic [Y_W-1:0]    row_s0;
  logic [BIT_W-1:0]  bit_s0;
  logic [SUB_W-1:0]  sub_s0;
  logic              blank_s0;
  logic              cur_s0;
  logic [TXT_AW-1:0] txt_addr_d, txt_addr_q;

  // Stage 2/4 side-band
  logic [SBA_W-1:0]  sba;
  logic [SBB_W-1:0]  sbb;
  logic              cur_s2, blank_s2, cur_s4, blank_s4;
  logic [BIT_W-1:0]  bit_s2, bit_s4;
  logic [SUB_W-1:0]  sub_s2;
  logic [7:0]        attr_s4;

  logic [7:0]        gidx;
  logic [GLY_AW-1:0] gly_addr_d, gly_addr_q;

  logic [BLINK_W-1:0] frame_q;
  logic               vs_prev_q;
  logic               blink_phase;

  logic [PIX_W-1:0]  fg, bg, fg_eff, pix_d, pix_q;

  // Cell address, in-cell position and blanking for the incoming raster position.
  always_comb begin
    col_s0     = posx / X_W'(GLYPH_W);
    row_s0     = posy / Y_W'(GLYPH_H);
    bit_s0     = BIT_W'(posx % X_W'(GLYPH_W));
    sub_s0     = SUB_W'(posy % Y_W'(GLYPH_H));
    blank_s0   = !de_in || (col_s0 >= X_W'(COLS)) || (row_s0 >= Y_W'(ROWS));
    txt_addr_d = blank_s0 ? '0 : TXT_AW'(32'(row_s0) * 32'(COLS) + 32'(col_s0));
`ifdef TXT_CURSOR_EN
    cur_s0     = cur_en && !blank_s0 &&
                 (col_s0 == X_W'(cur_col)) && (row_s0 == Y_W'(cur_row)) &&
                 (sub_s0 >= SUB_W'(GLYPH_H - TXT_CUR_LINES));
`else
    cur_s0     = 1'b0;
`endif
  end

  // E1: text RAM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txt_addr_q <= '0;
    else        txt_addr_q <= txt_addr_d;
  end

  // Side-band E1..E2: aligned with txt_chr/txt_attr coming back from the RAM.
  txt_delay_line #(.WIDTH(SBA_W), .DEPTH(2)) u_sb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({cur_s0, bit_s0, blank_s0, sub_s0}),
    .q_o   (sba)
  );
  assign {cur_s2, bit_s2, blank_s2, sub_s2} = sba;

  // Codes below the first stored glyph fall back to glyph 0 rather than wrapping.
  always_comb begin
    gidx       = (txt_chr < CHR_CODE) ? 8'd0 : (txt_chr - CHR_CODE);
    gly_addr_d = GLY_AW'(32'(gidx) * 32'(GLYPH_H) + 32'(sub_s2));
  end

  // E3: glyph ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gly_addr_q <= '0;
    else        gly_addr_q <= gly_addr_d;
  end

  // Attribute E3..E4: aligned with gly_row coming back from the ROM.
  txt_delay_line #(.WIDTH(8), .DEPTH(2)) u_attr (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (txt_attr),
    .q_o   (attr_s4)
  );

  // Side-band E3..E4.
  txt_delay_line #(.WIDTH(SBB_W), .DEPTH(2)) u_sb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({cur_s2, bit_s2, blank_s2}),
    .q_o   (sbb)
  );
  assign {cur_s4, bit_s4, blank_s4} = sbb;

  // Frame counter advances on each vs_in rising edge; its MSB is the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      vs_prev_q <= vs_in;
      if (vs_in && !vs_prev_q) frame_q <= frame_q + BLINK_W'(1);
    end
  end
  assign blink_phase = frame_q[BLINK_W-1];

  // Colour selection: blinking cells swap fg for bg in the off phase; cursor lines are solid fg.
  always_comb begin
    fg     = PIX_W'(attr_s4[ATTR_FG_MSB:ATTR_FG_LSB]);
    bg     = PIX_W'(attr_s4[ATTR_BG_MSB:ATTR_BG_LSB]);
    fg_eff = (attr_s4[ATTR_BLINK] && blink_phase) ? bg : fg;
    if (blank_s4)                   pix_d = '0;
    else if (cur_s4 && !blink_phase) pix_d = fg;
    else                            pix_d = gly_row[bit_s4] ? fg_eff : bg;
  end

  // E5: output colour index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  // Sync signals ride a matching five-stage pipe.
  txt_delay_line #(.WIDTH(3), .DEPTH(TXT_LAT)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({de_in, hs_in, vs_in}),
    .q_o   ({de_out, hs_out, vs_out})
  );

  assign txt_addr = txt_addr_q;
  assign gly_addr = gly_addr_q;
  assign pix      = pix_q;

endmodule

// File: tb/tb_txt_render_pipe.sv
// Scoreboard bench for txt_render_pipe (default build, cursor disabled).
module tb_txt_render_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  posx;
  logic [8:0]  posy;
  logic        de_in, hs_in, vs_in;
  logic [11:0] txt_addr;
  logic [7:0]  txt_chr  = 8'h00;
  logic [7:0]  txt_attr = 8'h00;
  logic [11:0] gly_addr;
  logic [7:0]  gly_row  = 8'h00;
  logic [3:0]  pix;
  logic        de_out, hs_out, vs_out;

  logic [7:0] chr_mem  [4096];
  logic [7:0] attr_mem [4096];
  logic [7:0] gly_mem  [4096];

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t q_pix[$];
  exp_t q_ta[$];
  exp_t q_ga[$];
  exp_t me;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  txt_render_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .posx     (posx),
    .posy     (posy),
    .de_in    (de_in),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .txt_addr (txt_addr),
    .txt_chr  (txt_chr),
    .txt_attr (txt_attr),
    .gly_addr (gly_addr),
    .gly_row  (gly_row),
    .pix      (pix),
    .de_out   (de_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out)
`ifdef TXT_CURSOR_EN
    ,
    .cur_en   (1'b0),
    .cur_col  (7'd0),
    .cur_row  (5'd0)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle text RAM and glyph ROM models.
  always @(posedge clk) begin
    txt_chr  <= chr_mem[txt_addr];
    txt_attr <= attr_mem[txt_addr];
    gly_row  <= gly_mem[gly_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whose due cycle has arrived and compares.
  always @(negedge clk) begin
    while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
      me = q_pix.pop_front();
      if (me.due != cyc) begin
        n_tests++; n_fail++;
        $display("FAIL pix_late: due %0d, now %0d", me.due, cyc);
      end else check("pix_de_hs_vs", 32'({pix, de_out, hs_out, vs_out}), me.val);
    end
    while (q_ta.size() > 0 && q_ta[0].due <= cyc) begin
      me = q_ta.pop_front();
      if (me.due != cyc) begin
        n_tests++; n_fail++;
        $display("FAIL txt_addr_late: due %0d, now %0d", me.due, cyc);
      end else check("txt_addr", 32'(txt_addr), me.val);
    end
    while (q_ga.size() > 0 && q_ga[0].due <= cyc) begin
      me = q_ga.pop_front();
      if (me.due != cyc) begin
        n_tests++; n_fail++;
        $display("FAIL gly_addr_late: due %0d, now %0d", me.due, cyc);
      end else check("gly_addr", 32'(gly_addr), me.val);
    end
  end

  // Drive one pixel and queue its expected outputs (eta/ega < 0: not checked).
  task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs,
                       input int epix, input int eta, input int ega);
    exp_t e;
    posx = 10'(x); posy = 9'(y); de_in = de; hs_in = hs; vs_in = vs;
    e.due = cyc + 5; e.val = 32'({4'(epix), de, hs, vs}); q_pix.push_back(e);
    if (eta >= 0) begin e.due = cyc + 1; e.val = 32'(eta); q_ta.push_back(e); end
    if (ega >= 0) begin e.due = cyc + 3; e.val = 32'(ega); q_ga.push_back(e); end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0, 1'b0, 0, -1, -1);
  endtask

  int exp_line[8] = '{1, 1, 15, 15, 15, 15, 1, 1};
  int guard;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      chr_mem[i] = 8'h20; attr_mem[i] = 8'h00; gly_mem[i] = 8'h00;
    end
    chr_mem[0]     = 8'h41; attr_mem[0]    = 8'h1F; gly_mem[12'h210] = 8'h3C;
    chr_mem[2399]  = 8'h10; attr_mem[2399] = 8'h9F; gly_mem[15]      = 8'hFF;
    chr_mem[1]     = 8'h20; attr_mem[1]    = 8'h27;
    chr_mem[2]     = 8'h10; attr_mem[2]    = 8'h35; gly_mem[5]       = 8'h01;

    rst_n = 1'b0; posx = '0; posy = '0; de_in = 0; hs_in = 0; vs_in = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_pix", 32'(pix), 0);
    check("rst_de_out", 32'(de_out), 0);
    check("rst_hs_out", 32'(hs_out), 0);
    check("rst_vs_out", 32'(vs_out), 0);
    check("rst_txt_addr", 32'(txt_addr), 0);
    check("rst_gly_addr", 32'(gly_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cell (0,0): 'A' with fg F / bg 1, glyph row 0x3C.
    for (int x = 0; x < 8; x++) drive(x, 0, 1'b1, 1'b0, 1'b0, exp_line[x], 0, (x == 0) ? 12'h210 : -1);
    idle(6);

    // Last visible cell, then column 80 (blank).
    drive(639, 479, 1'b1, 1'b0, 1'b0, 15, 2399, 15);
    drive(640, 479, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    idle(6);

    // Codes 0x20 and 0x10 both map to glyph 0.
    drive(8, 5, 1'b1, 1'b0, 1'b0, 7, 1, 5);
    drive(16, 5, 1'b1, 1'b0, 1'b0, 5, 2, 5);
    idle(6);

    // hsync pulse during blanking.
    idle(2);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    idle(6);

    // Blink: attr 0x9F, glyph bit set, frames 0..32.
    for (int f = 0; f <= 32; f++) begin
      drive(639, 479, 1'b1, 1'b0, 1'b0, ((f % 32) < 16) ? 15 : 1, -1, -1);
      idle(6);
      drive(0, 0, 1'b0, 1'b0, 1'b1, 0, -1, -1);
      idle(2);
    end
    // Counter now at 33; advance to 48 (phase 1).
    for (int p = 0; p < 15; p++) begin
      drive(0, 0, 1'b0, 1'b0, 1'b1, 0, -1, -1);
      idle(2);
    end
    drive(639, 479, 1'b1, 1'b0, 1'b0, 1, -1, -1);
    idle(6);

    // Mid-line reset.
    for (int x = 0; x < 8; x++) drive(x, 0, 1'b1, 1'b0, 1'b0, exp_line[x], 0, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_pix", 32'(pix), 0);
    check("midrst_de_out", 32'(de_out), 0);
    check("midrst_hs_out", 32'(hs_out), 0);
    check("midrst_vs_out", 32'(vs_out), 0);
    check("midrst_txt_addr", 32'(txt_addr), 0);
    q_pix.delete(); q_ta.delete(); q_ga.delete();
    de_in = 0;
    vs_in = 1'b1;
    @(posedge clk); #1;
    vs_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Frame counter restarted: blink phase 0, so fg shows.
    drive(639, 479, 1'b1, 1'b0, 1'b0, 15, 2399, 15);
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1, 0, 12'h210);
    idle(8);

    guard = 0;
    while ((q_pix.size() + q_ta.size() + q_ga.size()) > 0 && guard < 50) begin
      @(posedge clk); guard++;
    end
    if ((q_pix.size() + q_ta.size() + q_ga.size()) > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q_pix.size() + q_ta.size() + q_ga.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/txt_render_pipe.md
Name: txt_render_pipe

Overview:
- Parametrised, pipelined text-mode renderer; successor to the single-cycle combinational text controller.
- Converts the raster position from the video timing generator into text-RAM and glyph-ROM addresses.
- Applies per-cell colour attributes and blink, then outputs a colour index with the sync signals delay-matched.
- Sits between the timing generator, the text RAM (character + attribute, 1-cycle read), the glyph ROM (1-cycle read) and the palette/DAC stage.

Parameters:
- GLYPH_W, 8: glyph width in pixels (1..8); one ROM byte per glyph row.
- GLYPH_H, 16: glyph height in scanlines (power of two).
- COLS, 80: text columns.
- ROWS, 30: text rows.
- X_W, 10: posx width.
- Y_W, 9: posy width.
- TXT_AW, 12: text RAM address width.
- GLY_AW, 12: glyph ROM address width.
- CHR_BASE, 32: first character code stored in the glyph ROM.
- PIX_W, 4: output colour index width.
- BLINK_FRAMES, 32: frames per full blink period (power of two).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- posx  in  X_W  raster x
- posy  in  Y_W  raster y
- de_in  in  1  visible-area enable
- hs_in  in  1  hsync
- vs_in  in  1  vsync
- txt_addr  out  TXT_AW  text RAM address (registered)
- txt_chr  in  8  character code; valid one cycle after txt_addr
- txt_attr  in  8  attribute byte; valid one cycle after txt_addr
- gly_addr  out  GLY_AW  glyph ROM address (registered)
- gly_row  in  8  glyph row bits; valid one cycle after gly_addr
- pix  out  PIX_W  colour index
- de_out  out  1  delayed de_in
- hs_out  out  1  delayed hs_in
- vs_out  out  1  delayed vs_in

Behaviour:
- Reset: all pipeline registers, txt_addr, gly_addr, pix, de_out, hs_out, vs_out and the frame counter go to 0 immediately when rst_n falls. Reset applied mid-line discards in-flight pixels; output is valid from the 5th edge after release.
- Latency: fixed 5 edges from posx/posy/de_in/hs_in/vs_in to pix/de_out/hs_out/vs_out.
  - E1: register txt_addr, column bit, sub-row, blank flag.
  - E2: RAM registers txt_chr/txt_attr.
  - E3: register gly_addr and attribute.
  - E4: ROM registers gly_row.
  - E5: register pix.
- Sync and side-band data travel in the same shift pipeline.
- Address arithmetic:
  - col = posx / GLYPH_W; bit = posx % GLYPH_W.
  - row = posy / GLYPH_H; sub = posy % GLYPH_H.
  - txt_addr = row*COLS + col, truncated to TXT_AW.
- Blank cell: col >= COLS, row >= ROWS, or de_in low. The cell is flagged blank, txt_addr is held at 0, and pix = 0.
- Glyph address: gly_addr = (txt_chr - CHR_BASE)*GLYPH_H + sub. If txt_chr < CHR_BASE, glyph index 0 is used (no wrap); the result is truncated to GLY_AW.
- Pixel select: gly_row[bit], LSB = leftmost pixel. Bits at or above GLYPH_W are never selected.
- Attribute fields:
  - [3:0] foreground index.
  - [6:4] background index, zero-extended.
  - [7] blink.
  - Output: pix = glyph bit ? fg : bg.
- Blink counter:
  - Frame counter of log2(BLINK_FRAMES) bits increments on each registered rising edge of vs_in and wraps freely.
  - blink_phase = counter MSB.
  - When attr[7]=1 and blink_phase=1, fg is replaced by bg.
  - A vs_in rising edge during reset is ignored.
- No handshakes: RAM/ROM latency is fixed at 1 cycle; stalls are not supported.

Optional Feature:
- Macro: TXT_CURSOR_EN.
- When defined:
  - Adds ports cur_en (in, 1), cur_col (in, 7) and cur_row (in, 5).
  - In the cell matching cur_col/cur_row with cur_en=1, scanlines sub >= GLYPH_H-2 render fg for all pixels while blink_phase=0, and normal glyph output otherwise.
  - The cursor cell match is pipelined with the same latency.
- When undefined: the ports and logic are absent; output is identical to a build with cur_en=0.

Decomposition:
- Package txt_pkg:
  - Attribute field positions (ATTR_FG_LSB/MSB, ATTR_BG_LSB/MSB, ATTR_BLINK).
  - Pipeline latency constant TXT_LAT=5.
  - Cursor scanline count TXT_CUR_LINES=2.
- Sub-module: txt_delay_line. Parametrised width/depth shift register with async active-low reset, used for the de/hs/vs and side-band delays.

Test Plan:
- Cell (0,0) with txt_chr=0x41, txt_attr=0x1F, posy=0, so gly_addr=0x210; ROM returns gly_row=0x3C. Required: pix for x=0..7 is 1,1,F,F,F,F,1,1, starting 5 edges after x=0.
- posx=639, posy=479, de_in=1 -> txt_addr=2399, gly sub=15. posx=640 (col 80) -> pix=0, txt_addr=0.
- txt_chr=0x10 -> gly_addr equals the sub-row only (glyph 0); txt_chr=0x20 gives the same address.
- txt_attr=0x9F with gly_row=0xFF -> pix=F for frames 0..15, pix=1 for frames 16..31, pix=F again at frame 32 (counted by vs_in rising edges).
- One-cycle hs_in pulse with de_in low -> hs_out pulses exactly 5 edges later and pix=0 throughout.
- rst_n pulled low mid-line -> pix/de_out/hs_out/vs_out read 0 before the next edge. After release, the first valid pix appears on the 5th edge and the frame counter restarts at 0.
